m_mux16_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one 16-bit datapath between source A and source B.
- Drives the select of a 2:1 16-bit mux (0 = A, 1 = B) and registers the winning word into a single output stage.
- The output stage uses a valid/ready handshake toward the consumer.
- Sits between two producers (e.g. ALU result and memory read-back) and a shared 16-bit bus.

---
 rtl/m_mux16_arbiter.sv | 90 +++++++++
 tb/tb_m_mux16_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/m_mux16_arbiter.sv
// Two-requester round-robin arbiter feeding a registered 16-bit output stage with valid/ready.
// Grant is issued in the request cycle; the word appears on o_data 1 cycle later. Stalls while o_valid && !i_ready.
// Optional macro M_MUX16_ARBITER_FIXED_PRIO_EN: A always wins contention (B may starve).
module m_mux16_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_a,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic             i_req_b,
    input  logic [WIDTH-1:0] i_data_b,
    output logic             o_gnt_a,
    output logic             o_gnt_b,
    output logic             o_sel,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_src,
    input  logic             i_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             src_q, src_d;
    logic             last_q, last_d;

    logic             any_req;
    logic             winner;
    logic             load;

    always_comb begin
        any_req = i_req_a | i_req_b;
`ifdef M_MUX16_ARBITER_FIXED_PRIO_EN
        winner  = i_req_a ? 1'b0 : 1'b1;
`else
        // Under contention the side that did not win last time goes next.
        winner  = (i_req_a & i_req_b) ? ~last_q : i_req_b;
`endif
        load    = ((state_q == IDLE) | i_ready) & any_req & ~i_rst;
    end

    assign o_gnt_a = load & ~winner;
    assign o_gnt_b = load & winner;
    assign o_sel   = load ? winner : last_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_src   = src_q;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        if (load) begin
            state_d = winner ? HOLD_B : HOLD_A;
            valid_d = 1'b1;
            data_d  = winner ? i_data_b : i_data_a;
            src_d   = winner;
            last_d  = winner;
        end else if (valid_q & i_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_m_mux16_arbiter.sv
// Bench for m_mux16_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbiter's rules.
module tb_m_mux16_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, ready;
    logic [15:0] da, db;
    logic        gnt_a, gnt_b, sel, valid, src;
    logic [15:0] data;

    int ncmp  = 0;
    int nfail = 0;

    // Model of the output stage and the fairness pointer.
    logic        m_known = 1'b0;
    logic        m_valid, m_src, m_last;
    logic [15:0] m_data;
    // Combinational outputs snapshotted at the negedge of the last cycle.
    logic        s_gnt_a, s_gnt_b, s_sel;

    always #5 clk = ~clk;

    m_mux16_arbiter #(.WIDTH(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req_a (req_a),
        .i_data_a(da),
        .i_req_b (req_b),
        .i_data_b(db),
        .o_gnt_a (gnt_a),
        .o_gnt_b (gnt_b),
        .o_sel   (sel),
        .o_valid (valid),
        .o_data  (data),
        .o_src   (src),
        .i_ready (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare at negedge against the model, then advance the model past the edge.
    task automatic cycle();
        logic e_load, e_win;
        logic n_valid, n_src, n_last;
        logic [15:0] n_data;
        @(negedge clk);
        s_gnt_a = gnt_a;
        s_gnt_b = gnt_b;
        s_sel   = sel;
        e_load = !rst && (req_a || req_b) && (!m_valid || ready || !m_known);
        if (req_a && req_b) begin
`ifdef M_MUX16_ARBITER_FIXED_PRIO_EN
            e_win = 1'b0;
`else
            e_win = (m_last == 1'b1) ? 1'b0 : 1'b1;
`endif
        end else begin
            e_win = req_b;
        end
        if (m_known) begin
            check("gnt_a", {31'd0, gnt_a}, {31'd0, e_load && !e_win});
            check("gnt_b", {31'd0, gnt_b}, {31'd0, e_load && e_win});
            check("sel",   {31'd0, sel},   {31'd0, e_load ? e_win : m_last});
            check("valid", {31'd0, valid}, {31'd0, m_valid});
            check("data",  {16'd0, data},  {16'd0, m_data});
            check("src",   {31'd0, src},   {31'd0, m_src});
        end else if (rst) begin
            check("gnt_in_reset", {30'd0, gnt_a, gnt_b}, 32'd0);
        end
        n_valid = m_valid; n_src = m_src; n_last = m_last; n_data = m_data;
        if (rst) begin
            n_valid = 0; n_src = 0; n_last = 1; n_data = 16'h0;
        end else if (e_load) begin
            n_valid = 1; n_src = e_win; n_last = e_win; n_data = e_win ? db : da;
        end else if (m_valid && ready) begin
            n_valid = 0;
        end
        @(posedge clk);
        #1;
        if (rst) m_known = 1'b1;
        m_valid = n_valid; m_src = n_src; m_last = n_last; m_data = n_data;
    endtask

    task automatic do_reset();
        rst = 1; cycle(); rst = 0;
    endtask

    logic [15:0] exp_seq [4];
    logic        exp_gnt [4];

    initial begin
        rst = 1; req_a = 0; req_b = 0; ready = 1; da = 0; db = 0;
        @(posedge clk); #1;
        do_reset();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data",  {16'd0, data},  32'd0);
        check("rst_src",   {31'd0, src},   32'd0);

        // Single A word.
        req_a = 1; da = 16'h1234; cycle();
        check("t1_gnt_a", {31'd0, s_gnt_a}, 32'd1);
        check("t1_valid", {31'd0, valid}, 32'd1);
        check("t1_data",  {16'd0, data},  32'h1234);
        check("t1_src",   {31'd0, src},   32'd0);
        req_a = 0; cycle();
        check("t1_valid_fall", {31'd0, valid}, 32'd0);

        // Continuous contention.
        do_reset();
        req_a = 1; req_b = 1; da = 16'hAAAA; db = 16'h5555;
`ifdef M_MUX16_ARBITER_FIXED_PRIO_EN
        exp_gnt = '{0, 0, 0, 0};
        exp_seq = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
`else
        exp_gnt = '{0, 1, 0, 1};
        exp_seq = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
`endif
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_gnt_b", {31'd0, s_gnt_b}, {31'd0, exp_gnt[i]});
            check("t2_data",  {16'd0, data},    {16'd0, exp_seq[i]});
            check("t2_valid", {31'd0, valid},   32'd1);
        end
`ifdef M_MUX16_ARBITER_FIXED_PRIO_EN
        req_a = 0; cycle();
        check("t2_b_after_a_drop", {31'd0, s_gnt_b}, 32'd1);
`endif
        req_a = 0; req_b = 0; cycle();

        // B word then stall while A waits; also the o_sel check in IDLE.
        do_reset();
        req_b = 1; db = 16'hBEEF; cycle();
        check("t3_gnt_b", {31'd0, s_gnt_b}, 32'd1);
        check("t3_sel",   {31'd0, s_sel},   32'd1);
        check("t3_src",   {31'd0, src},     32'd1);
        req_b = 0; req_a = 1; da = 16'h0F0F; ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_stall_gnt_a", {31'd0, s_gnt_a}, 32'd0);
            check("t3_stall_data",  {16'd0, data},    32'hBEEF);
        end
        ready = 1; cycle();
        check("t3_gnt_a", {31'd0, s_gnt_a}, 32'd1);
        check("t3_data",  {16'd0, data},    32'h0F0F);
        req_a = 0;

        // Reset while holding a word with both requesting.
        req_a = 1; req_b = 1; ready = 0; rst = 1; cycle();
        check("t4_gnt", {30'd0, s_gnt_a, s_gnt_b}, 32'd0);
        check("t4_valid", {31'd0, valid}, 32'd0);
        check("t4_data",  {16'd0, data},  32'd0);
        rst = 0; ready = 1; cycle();
        check("t4_first_gnt_a", {31'd0, s_gnt_a}, 32'd1);
        req_a = 0; req_b = 0; cycle();

        // Random traffic obeying the hold-until-granted rule (with occasional withdrawal).
        for (int n = 0; n < 3000; n++) begin
            if (req_a && s_gnt_a) req_a = 0;
            if (req_b && s_gnt_b) req_b = 0;
            if (req_a && $urandom_range(0, 15) == 0) req_a = 0;
            if (req_b && $urandom_range(0, 15) == 0) req_b = 0;
            if (!req_a && $urandom_range(0, 2) != 0) begin req_a = 1; da = 16'($urandom); end
            if (!req_b && $urandom_range(0, 2) != 0) begin req_b = 1; db = 16'($urandom); end
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 199) == 0);
            cycle();
            if (rst) begin req_a = 0; req_b = 0; end
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
